// File: rtl/fetch_pkg.sv
// Shared constants and the instruction-queue entry type for the fetch unit.
package fetch_pkg;
  localparam int INSN_W   = 32;
  localparam int PC_INC   = 4;
  localparam int PC_MAX_W = 64;

  // The pc field is sized for the widest supported XLEN; narrower fetch units zero-extend into it.
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INSN_W-1:0]   ins;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and an occupancy count; head is the oldest entry.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential PCs, pairs in-order responses with their PCs,
// and buffers instructions for decode; redirects flush the queue and drop stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_ins,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pcp4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_head;
  logic [CW-1:0]   pc_count;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   inflight;
  logic [CW:0]     occupancy;
  logic            fire;
  logic            rsp_live;
  logic            rsp_keep;
  logic            pop;
  fetch_entry_t    q_in;
  fetch_entry_t    q_head;
  logic            unused_bits;

  // Requests still owed by memory include those whose responses will be discarded.
  assign inflight  = pc_count + drop;
  assign occupancy = {1'b0, inflight} + {1'b0, q_count};

  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < DEPTH_L);
  assign imem_addr      = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_live && (drop == '0) && !redirect_valid;

  assign out_valid = (q_count != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    q_in     = '0;
    q_in.pc  = PC_MAX_W'(pc_head);
    q_in.ins = imem_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      drop     <= inflight - CW'(rsp_live);
    end else begin
      if (fire) fetch_pc <= fetch_pc + XLEN'(PC_INC);
      if (rsp_live && (drop != '0)) drop <= drop - CW'(1);
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (pc_head),
    .count     (pc_count)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_ins_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (rsp_keep),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  assign out_ins  = q_head.ins;
  assign out_pc   = q_head.pc[XLEN-1:0];
  assign out_pcp4 = out_pc + XLEN'(PC_INC);

  assign unused_bits = ^{q_head.pc, redirect_pc[1:0]};

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries and the outstanding-request limit (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port redirect_valid  in  1  taken branch, jump or flush request.
REQ-007 SHALL have port redirect_pc  in  XLEN  new fetch target.
REQ-008 SHALL have port imem_req_valid  out  1  fetch request.
REQ-009 SHALL have port imem_req_ready  in  1  memory accepts the request.
REQ-010 SHALL have port imem_addr  out  XLEN  fetch address.
REQ-011 SHALL have port imem_rsp_valid  in  1  in-order instruction return.
REQ-012 SHALL have port imem_rsp_data  in  32  returned instruction.
REQ-013 SHALL have port out_valid  out  1  decode-side valid.
REQ-014 SHALL have port out_ready  in  1  decode-side ready.
REQ-015 SHALL have port out_ins  out  32  instruction.
REQ-016 SHALL have port out_pc  out  XLEN  PC of out_ins.
REQ-017 SHALL have port out_pcp4  out  XLEN  out_pc+4.

Function
REQ-018 SHALL keep fetch_pc; imem_addr=fetch_pc; a request fires when imem_req_valid && imem_req_ready; fetch_pc advances by 4 modulo 2^XLEN on each fire (0xFFFFFFFC wraps to 0x0).
REQ-019 SHALL drive imem_req_valid = rst_n && !redirect_valid && (inflight+count) < DEPTH, so the queue can never overflow.
REQ-020 SHALL record the PC of every fired request in order and pair it with the next non-dropped response.
REQ-021 SHALL push {pc, imem_rsp_data} into the queue on a non-dropped imem_rsp_valid; the response may arrive as early as the cycle after its request.
REQ-022 SHALL drive out_valid=(count!=0) and present the queue head; it pops on out_valid && out_ready; push and pop in the same cycle leave count unchanged.
REQ-023 SHALL hold out_ins/out_pc/out_pcp4 stable while out_valid && !out_ready.
REQ-024 SHALL compute out_pcp4 = out_pc+4 modulo 2^XLEN.
REQ-025 SHALL, on redirect_valid: clear the queue (out_valid=0 next cycle), set fetch_pc=redirect_pc with bits [1:0] forced to 0, and set drop=inflight minus 1 if imem_rsp_valid is high that cycle, else drop=inflight.
REQ-026 SHALL discard responses while drop>0, decrementing drop once per discard; requests resume the cycle after the redirect.
REQ-027 SHALL give redirect priority over any simultaneous push, pop or request.
REQ-028 SHALL ignore imem_rsp_valid when inflight=0.

Reset
REQ-029 SHALL, on a rising clk with rst_n=0, set fetch_pc=RESET_PC, count=0, inflight=0, drop=0, out_valid=0, and imem_req_valid=0.
REQ-030 SHALL, on reset mid-operation, discard all queued and in-flight state; responses arriving while rst_n=0 are ignored.
REQ-031 SHALL issue the first request at RESET_PC in the first cycle with rst_n=1.

Structure
REQ-032 SHALL take INSN_W=32, PC_INC=4 and the queue-entry struct {pc, ins} from the shared package fetch_pkg.
REQ-033 SHALL use one sub-module, sync_fifo (parametrised width/depth, count output), instantiated for the in-flight PC list and the instruction queue.

Verification
REQ-034 SHALL cover: reset, then 1-cycle memory with out_ready=1 -> out_pc sequence 0x0,0x4,0x8,... with out_pcp4 = out_pc+4.
REQ-035 SHALL cover: out_ready=0 for 10 cycles -> exactly DEPTH (4) entries queued, at most 4 requests in flight, head held stable.
REQ-036 SHALL cover: redirect to 0x100 with 2 requests in flight -> 2 responses dropped, next out_pc=0x100.
REQ-037 SHALL cover: redirect_pc=0x203 -> fetch at 0x200.
REQ-038 SHALL cover: RESET_PC=0xFFFFFFF8 -> out_pc 0xFFFFFFF8,0xFFFFFFFC,0x0.
REQ-039 SHALL cover: rst_n low mid-stream with responses pending -> out_valid=0, the next request at RESET_PC, and no stale instruction emitted.
